// File: rtl/clk_delay_multi.sv
// clk_delay_multi: multi-channel, event-queued emulated clock delay.
//
// Each channel watches its emulated input clock value. Every edge is queued
// with a remaining delay of code*DLY_STEP + DLY_OFFSET ticks. The queue is
// aged by the granted timestep emu_dt, and the head entry drives the output
// once its remaining time is covered. The block requests the smallest head
// remaining time across channels, capped by dt_req_max.
//
// Optional feature: define CLK_DELAY_MULTI_JITTER_EN to add a per-channel
// 16-bit LFSR whose low 3 bits (signed -4..+3) perturb each captured delay.
//
// Ports:
//   emu_clk     emulator clock
//   emu_rst     asynchronous active-high reset
//   code        per-channel delay code, channel i at [i*CODE_WIDTH +: CODE_WIDTH]
//   clk_i_val   emulated input clock values
//   emu_dt      timestep granted for this emu_clk cycle (signed)
//   dt_req_max  upper bound on the timestep request (signed)
//   dt_req      requested timestep, combinational from state
//   clk_o_val   delayed clock values (registered)
//   overflow    sticky per-channel queue-overflow flags

module clk_delay_multi #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned CODE_WIDTH = 8,
   parameter int unsigned DT_WIDTH   = 25,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DLY_STEP   = 4,
   parameter int unsigned DLY_OFFSET = 10
) (
   input  logic                       emu_clk,
   input  logic                       emu_rst,
   input  logic [N_CH*CODE_WIDTH-1:0] code,
   input  logic [N_CH-1:0]            clk_i_val,
   input  logic [DT_WIDTH-1:0]        emu_dt,
   input  logic [DT_WIDTH-1:0]        dt_req_max,
   output logic [DT_WIDTH-1:0]        dt_req,
   output logic [N_CH-1:0]            clk_o_val,
   output logic [N_CH-1:0]            overflow
);

   localparam int unsigned RW = DT_WIDTH - 1;           // remaining-time width
   localparam int unsigned CW = $clog2(DEPTH + 1);      // occupancy counter width
   localparam int unsigned DW = DT_WIDTH + 2;           // signed delay working width

   localparam logic signed [DW-1:0] STEP_S = DW'(DLY_STEP);
   localparam logic signed [DW-1:0] OFF_S  = DW'(DLY_OFFSET);
   localparam logic signed [DW-1:0] ONE_S  = DW'(1);
   localparam logic signed [DW-1:0] SAT_S  = {3'b000, {RW{1'b1}}};

   logic [RW-1:0]    rem_q [N_CH][DEPTH];
   logic [RW-1:0]    rem_d [N_CH][DEPTH];
   logic [DEPTH-1:0] val_q [N_CH];
   logic [DEPTH-1:0] val_d [N_CH];
   logic [CW-1:0]    cnt_q [N_CH];
   logic [CW-1:0]    cnt_d [N_CH];
   logic [CW-1:0]    cnt_mid [N_CH];
   logic [N_CH-1:0]  prev_q, out_q, out_d, ovf_q, ovf_d;
   logic [N_CH-1:0]  pop, push;
   logic [RW-1:0]    step, req;
   logic signed [DW-1:0] dly_raw [N_CH];
   logic [RW-1:0]    dly [N_CH];

`ifdef CLK_DELAY_MULTI_JITTER_EN
   logic [15:0] lfsr_q [N_CH];
   logic [15:0] lfsr_d [N_CH];
`endif

   // Clamp to [1, 2^(DT_WIDTH-1)-1]; zero or negative delays become one tick.
   function automatic logic [RW-1:0] clamp_delay(input logic signed [DW-1:0] raw);
      if (raw < ONE_S) begin
         return RW'(1);
      end else if (raw > SAT_S) begin
         return {RW{1'b1}};
      end else begin
         return raw[RW-1:0];
      end
   endfunction

   // Negative grants are treated as zero.
   always_comb begin
      step = emu_dt[DT_WIDTH-1] ? '0 : emu_dt[RW-1:0];
   end

   always_comb begin
      for (int ch = 0; ch < N_CH; ch++) begin
         dly_raw[ch] = $signed({{(DW-CODE_WIDTH){1'b0}}, code[ch*CODE_WIDTH +: CODE_WIDTH]})
                       * STEP_S + OFF_S;
`ifdef CLK_DELAY_MULTI_JITTER_EN
         dly_raw[ch] = dly_raw[ch] + $signed({{(DW-3){lfsr_q[ch][2]}}, lfsr_q[ch][2:0]});
`endif
         dly[ch] = clamp_delay(dly_raw[ch]);
      end
   end

   // Request: minimum of the capped maximum and every valid head.
   always_comb begin
      req = dt_req_max[DT_WIDTH-1] ? '0 : dt_req_max[RW-1:0];
      for (int ch = 0; ch < N_CH; ch++) begin
         if (cnt_q[ch] != '0 && rem_q[ch][0] < req) begin
            req = rem_q[ch][0];
         end
      end
      dt_req = {1'b0, req};
   end

   always_comb begin : p_next
      int unsigned src;
      src     = 0;
      rem_d   = rem_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      cnt_mid = cnt_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      pop     = '0;
      push    = '0;
`ifdef CLK_DELAY_MULTI_JITTER_EN
      lfsr_d  = lfsr_q;
`endif
      for (int ch = 0; ch < N_CH; ch++) begin
         // Step: pop the head if covered, age everything that remains.
         pop[ch]     = (cnt_q[ch] != '0) && (rem_q[ch][0] <= step);
         cnt_mid[ch] = cnt_q[ch] - CW'(pop[ch]);
         if (pop[ch]) begin
            out_d[ch] = val_q[ch][0];
         end
         for (int j = 0; j < DEPTH; j++) begin
            src = pop[ch] ? j + 1 : j;
            if (src < DEPTH) begin
               rem_d[ch][j] = (rem_q[ch][src] > step) ? rem_q[ch][src] - step : '0;
               val_d[ch][j] = val_q[ch][src];
            end else begin
               rem_d[ch][j] = '0;
               val_d[ch][j] = 1'b0;
            end
         end

         // Capture: occupancy is checked after the pop, so pop+push on full works.
         push[ch] = clk_i_val[ch] ^ prev_q[ch];
         if (push[ch]) begin
            if (cnt_mid[ch] < CW'(DEPTH)) begin
               for (int j = 0; j < DEPTH; j++) begin
                  if (cnt_mid[ch] == CW'(j)) begin
                     rem_d[ch][j] = dly[ch];
                     val_d[ch][j] = clk_i_val[ch];
                  end
               end
               cnt_d[ch] = cnt_mid[ch] + CW'(1);
            end else begin
               cnt_d[ch] = cnt_mid[ch];
               ovf_d[ch] = 1'b1;
            end
`ifdef CLK_DELAY_MULTI_JITTER_EN
            // Fibonacci LFSR, taps 16,15,13,4.
            lfsr_d[ch] = {lfsr_q[ch][14:0],
                          lfsr_q[ch][15] ^ lfsr_q[ch][14] ^ lfsr_q[ch][12] ^ lfsr_q[ch][3]};
`endif
         end else begin
            cnt_d[ch] = cnt_mid[ch];
         end
      end
   end

   always_ff @(posedge emu_clk or posedge emu_rst) begin
      if (emu_rst) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            for (int j = 0; j < DEPTH; j++) begin
               rem_q[ch][j] <= '0;
            end
            val_q[ch] <= '0;
            cnt_q[ch] <= '0;
`ifdef CLK_DELAY_MULTI_JITTER_EN
            lfsr_q[ch] <= 16'hACE1 ^ 16'(ch);
`endif
         end
         prev_q <= '0;
         out_q  <= '0;
         ovf_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         val_q  <= val_d;
         cnt_q  <= cnt_d;
`ifdef CLK_DELAY_MULTI_JITTER_EN
         lfsr_q <= lfsr_d;
`endif
         prev_q <= clk_i_val;
         out_q  <= out_d;
         ovf_q  <= ovf_d;
      end
   end

   assign clk_o_val = out_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_clk_delay_multi.sv
// Directed testbench for clk_delay_multi with N_CH=2, DT_WIDTH=16,
// dt_req_max=1000 and a loopback grant (emu_dt = dt_req) unless forced.

module tb_clk_delay_multi;

   logic        emu_clk;
   logic        emu_rst;
   logic [15:0] code;
   logic [1:0]  clk_i_val;
   logic [15:0] emu_dt;
   logic [15:0] dt_req_max;
   logic [15:0] dt_req;
   logic [1:0]  clk_o_val;
   logic [1:0]  overflow;

   logic        loop_en;
   logic [15:0] dt_force;

   int checks;
   int errors;

   assign emu_dt = loop_en ? dt_req : dt_force;

   clk_delay_multi #(
      .N_CH       (2),
      .CODE_WIDTH (8),
      .DT_WIDTH   (16),
      .DEPTH      (4),
      .DLY_STEP   (4),
      .DLY_OFFSET (10)
   ) dut (
      .emu_clk    (emu_clk),
      .emu_rst    (emu_rst),
      .code       (code),
      .clk_i_val  (clk_i_val),
      .emu_dt     (emu_dt),
      .dt_req_max (dt_req_max),
      .dt_req     (dt_req),
      .clk_o_val  (clk_o_val),
      .overflow   (overflow)
   );

   initial emu_clk = 1'b0;
   always #5 emu_clk = ~emu_clk;

   task automatic tick;
      @(posedge emu_clk);
      #1;
   endtask

   task automatic test_reset;
      emu_rst    = 1'b1;
      code       = 16'h0000;
      clk_i_val  = 2'b00;
      dt_req_max = 16'd1000;
      loop_en    = 1'b1;
      dt_force   = 16'd0;
      #12;
      @(negedge emu_clk);
      emu_rst = 1'b0;
      tick();
      tick();
      checks++;
      if (dt_req !== 16'd1000) begin
         errors++;
         $display("FAIL reset_dt_req: got %0d expected 1000", dt_req);
      end
      checks++;
      if (clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL reset_clk_o_val: got %b expected 00", clk_o_val);
      end
      checks++;
      if (overflow !== 2'b00) begin
         errors++;
         $display("FAIL reset_overflow: got %b expected 00", overflow);
      end
   endtask

   task automatic test_single_edge;
      code = {8'd0, 8'd5};
      clk_i_val[0] = 1'b1;
      tick();                            // edge k captures, delay 30
      checks++;
      if (dt_req !== 16'd30) begin
         errors++;
         $display("FAIL single_dt_req: got %0d expected 30", dt_req);
      end
      checks++;
      if (clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL single_out_before: got %b expected 00", clk_o_val);
      end
      tick();                            // edge k+1 pops
      checks++;
      if (clk_o_val !== 2'b01) begin
         errors++;
         $display("FAIL single_out_after: got %b expected 01", clk_o_val);
      end
      checks++;
      if (dt_req !== 16'd1000) begin
         errors++;
         $display("FAIL single_dt_req_idle: got %0d expected 1000", dt_req);
      end
      clk_i_val[0] = 1'b0;
      tick();
      tick();
      checks++;
      if (clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL single_fall: got %b expected 00", clk_o_val);
      end
   endtask

   task automatic test_two_channels;
      code = {8'd0, 8'd5};
      clk_i_val = 2'b11;
      tick();
      checks++;
      if (dt_req !== 16'd10) begin
         errors++;
         $display("FAIL two_dt_req_first: got %0d expected 10", dt_req);
      end
      tick();
      checks++;
      if (clk_o_val !== 2'b10) begin
         errors++;
         $display("FAIL two_ch1_rise: got %b expected 10", clk_o_val);
      end
      checks++;
      if (dt_req !== 16'd20) begin
         errors++;
         $display("FAIL two_dt_req_second: got %0d expected 20", dt_req);
      end
      tick();
      checks++;
      if (clk_o_val !== 2'b11) begin
         errors++;
         $display("FAIL two_ch0_rise: got %b expected 11", clk_o_val);
      end
      clk_i_val = 2'b00;
      tick();
      tick();
      tick();
      checks++;
      if (clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL two_fall: got %b expected 00", clk_o_val);
      end
   endtask

   task automatic test_partial_steps;
      logic [15:0] exp_rem [4];
      exp_rem[0] = 16'd23;
      exp_rem[1] = 16'd16;
      exp_rem[2] = 16'd9;
      exp_rem[3] = 16'd2;
      code = {8'd0, 8'd5};
      loop_en  = 1'b0;
      dt_force = 16'd7;
      clk_i_val[0] = 1'b1;
      tick();                            // capture, rem 30 not aged this cycle
      checks++;
      if (dt_req !== 16'd30) begin
         errors++;
         $display("FAIL partial_capture: got %0d expected 30", dt_req);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (dt_req !== exp_rem[i] || clk_o_val[0] !== 1'b0) begin
            errors++;
            $display("FAIL partial_step%0d: got rem %0d out %b expected rem %0d out 0",
                     i, dt_req, clk_o_val[0], exp_rem[i]);
         end
      end
      tick();                            // 5th edge pops
      checks++;
      if (clk_o_val[0] !== 1'b1) begin
         errors++;
         $display("FAIL partial_pop: got %b expected 1", clk_o_val[0]);
      end
      loop_en = 1'b1;
      clk_i_val[0] = 1'b0;
      tick();
      tick();
      checks++;
      if (clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL partial_fall: got %b expected 00", clk_o_val);
      end
   endtask

   task automatic test_overflow;
      logic [3:0] exp_out;
      exp_out  = 4'b0101;                // drained values in order: 1,0,1,0
      code     = {8'd0, 8'd5};
      loop_en  = 1'b0;
      dt_force = 16'd0;
      for (int i = 0; i < 5; i++) begin
         clk_i_val[0] = ~clk_i_val[0];
         tick();
         if (i == 3) begin
            checks++;
            if (overflow !== 2'b00) begin
               errors++;
               $display("FAIL ovf_not_yet: got %b expected 00", overflow);
            end
         end
      end
      checks++;
      if (overflow !== 2'b01) begin
         errors++;
         $display("FAIL ovf_set: got %b expected 01", overflow);
      end
      checks++;
      if (dt_req !== 16'd30) begin
         errors++;
         $display("FAIL ovf_dt_req: got %0d expected 30", dt_req);
      end
      loop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (clk_o_val[0] !== exp_out[i]) begin
            errors++;
            $display("FAIL ovf_drain%0d: got %b expected %b", i, clk_o_val[0], exp_out[i]);
         end
      end
      checks++;
      if (dt_req !== 16'd1000 || overflow !== 2'b01) begin
         errors++;
         $display("FAIL ovf_after_drain: got dt %0d ovf %b expected dt 1000 ovf 01",
                  dt_req, overflow);
      end
      clk_i_val[0] = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid;
      loop_en  = 1'b0;
      dt_force = 16'd0;
      code     = {8'd0, 8'd5};           // first edge 30 ticks
      clk_i_val[0] = 1'b1;
      tick();
      code     = {8'd0, 8'd10};          // remaining edges 50 ticks
      clk_i_val[0] = 1'b0;
      tick();
      clk_i_val[0] = 1'b1;
      tick();
      clk_i_val[0] = 1'b0;
      tick();
      dt_force = 16'd30;
      tick();                            // pop head, others age to 20
      dt_force = 16'd0;
      checks++;
      if (clk_o_val[0] !== 1'b1 || dt_req !== 16'd20) begin
         errors++;
         $display("FAIL mid_pending: got out %b dt %0d expected out 1 dt 20",
                  clk_o_val[0], dt_req);
      end
      #3;
      emu_rst = 1'b1;
      #1;
      checks++;
      if (clk_o_val !== 2'b00 || overflow !== 2'b00 || dt_req !== 16'd1000) begin
         errors++;
         $display("FAIL mid_async_clear: got out %b ovf %b dt %0d expected 00 00 1000",
                  clk_o_val, overflow, dt_req);
      end
      @(negedge emu_clk);
      @(negedge emu_clk);
      emu_rst = 1'b0;
      loop_en = 1'b1;
      tick();
      tick();
      checks++;
      if (dt_req !== 16'd1000 || clk_o_val !== 2'b00) begin
         errors++;
         $display("FAIL mid_after_release: got dt %0d out %b expected 1000 00",
                  dt_req, clk_o_val);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_edge();
      test_two_channels();
      test_partial_steps();
      test_overflow();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
